// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared vector-unit definitions: register/memory widths, beat count,
// the vector memory sequencer state encoding and the vector op codes
// used by decode and by the sequencer.
// ---------------------------------------------------------------------------
package vec_pkg;

    localparam int unsigned VLEN   = 128;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned VRA_W  = 3;
    localparam int unsigned NWORDS = VLEN / XLEN;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_XFER   = 2'd1,
        SEQ_FINISH = 2'd2
    } seq_state_e;

    typedef enum logic [4:0] {
        VOP_VADD     = 5'b00000,
        VOP_VSUB     = 5'b00001,
        VOP_VMUL     = 5'b00010,
        VOP_VLD      = 5'b00100,
        VOP_VST      = 5'b00101,
        VOP_VMOV_S2V = 5'b01000,
        VOP_VMOV_V2S = 5'b01001
    } vec_op_e;

endpackage

// File: rtl/vec_mem_sequencer.sv
// ---------------------------------------------------------------------------
// vec_mem_sequencer
// Moves one VLEN-bit vector register through the XLEN-bit data-memory port,
// one word per beat (word 0 at the lowest address). Loads assemble the
// vector and write it to the vector RF; stores stream the captured source.
// The scalar front end is stalled for the whole transfer.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/store/addr  vector memory instruction from execute
//   req_vreg, req_wdata   vector register index / VST source data
//   stall                 freeze pipeline front end
//   mem_req/we/addr/      memory beat request, handshaked by mem_ready;
//   mem_wdata/wstrb       load data returns on mem_rdata with mem_ready
//   vrf_we/waddr/wdata    vector RF write port (loads only)
//   done, err             completion pulse; err marks a misaligned abort
// ---------------------------------------------------------------------------
module vec_mem_sequencer
    import vec_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_store,
    input  logic [31:0]      req_addr,
    input  logic [VRA_W-1:0] req_vreg,
    input  logic [VLEN-1:0]  req_wdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             vrf_we,
    output logic [VRA_W-1:0] vrf_waddr,
    output logic [VLEN-1:0]  vrf_wdata,
    output logic             done,
    output logic             err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    seq_state_e                   r_state;
    seq_state_e                   w_next;
    logic [IDX_W-1:0]             r_idx;
    logic                         r_err;
    logic [31:0]                  r_addr;
    logic [VRA_W-1:0]             r_vreg;
    logic                         r_store;
    logic [NWORDS-1:0][XLEN-1:0]  r_wdata;
    logic [NWORDS-1:0][XLEN-1:0]  r_buf;

    logic                         w_accept;
    logic                         w_beat;
    logic                         w_misaligned;
    logic [31:0]                  w_beat_addr;

    assign w_misaligned = (req_addr[1:0] != 2'b00);
    // Byte address of the current beat; wraps modulo 2^32.
    assign w_beat_addr  = r_addr + (32'(r_idx) << 2);
    assign vrf_wdata    = r_buf;

    // Control state, beat index and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEQ_IDLE;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx <= '0;
                r_err <= w_misaligned;
            end else if (w_beat && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Request capture and load assembly buffer; the buffer survives reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= req_addr;
            r_vreg  <= req_vreg;
            r_store <= req_store;
            r_wdata <= req_wdata;
        end
        if (w_beat && !r_store) begin
            r_buf[r_idx] <= mem_rdata;
        end
    end

    // Next state and outputs.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_beat    = 1'b0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = 4'h0;
        vrf_we    = 1'b0;
        vrf_waddr = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (req_valid) begin
                    stall    = 1'b1;
                    w_accept = 1'b1;
                    // Misaligned requests skip memory entirely.
                    w_next   = w_misaligned ? SEQ_FINISH : SEQ_XFER;
                end
            end
            SEQ_XFER: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = r_store;
                mem_addr  = w_beat_addr;
                mem_wdata = r_wdata[r_idx];
                mem_wstrb = r_store ? 4'hF : 4'h0;
                if (mem_ready) begin
                    w_beat = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_next = SEQ_FINISH;
                    end
                end
            end
            SEQ_FINISH: begin
                done   = 1'b1;
                err    = r_err;
                w_next = SEQ_IDLE;
                if (!r_store && !r_err) begin
                    vrf_we    = 1'b1;
                    vrf_waddr = r_vreg;
                end
            end
            default: begin
                w_next = SEQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_sequencer
// Directed and randomized transfers against a word-addressed memory model.
// Expected beat addresses, store data and assembled load vectors are derived
// from base + 4*i and the model contents.
// ---------------------------------------------------------------------------
module tb_vec_mem_sequencer;
    import vec_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_store;
    logic [31:0]      req_addr;
    logic [VRA_W-1:0] req_vreg;
    logic [VLEN-1:0]  req_wdata;
    logic             stall;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready;
    logic [XLEN-1:0]  mem_rdata;
    logic             vrf_we;
    logic [VRA_W-1:0] vrf_waddr;
    logic [VLEN-1:0]  vrf_wdata;
    logic             done;
    logic             err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_model [logic [31:0]];

    vec_mem_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_store (req_store),
        .req_addr  (req_addr),
        .req_vreg  (req_vreg),
        .req_wdata (req_wdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .vrf_we    (vrf_we),
        .vrf_waddr (vrf_waddr),
        .vrf_wdata (vrf_wdata),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_stall"}, 128'(stall), 128'(1'b0));
        chk({tag, "_mreq"},  128'(mem_req), 128'(1'b0));
        chk({tag, "_done"},  128'(done), 128'(1'b0));
        chk({tag, "_vrfwe"}, 128'(vrf_we), 128'(1'b0));
    endtask

    // One full transaction; waits holds a 2-bit stall count per beat.
    task automatic xfer(input logic st, input logic [31:0] a, input logic [VRA_W-1:0] v,
                        input logic [VLEN-1:0] wd, input logic [7:0] waits, input logic hold);
        logic [VLEN-1:0] exp_vec;
        logic [31:0]     ea;
        logic [31:0]     ed;
        logic [31:0]     rd;
        exp_vec   = '0;
        req_valid = 1'b1;
        req_store = st;
        req_addr  = a;
        req_vreg  = v;
        req_wdata = wd;
        mem_ready = 1'($urandom);
        #1;
        chk("acc_stall", 128'(stall), 128'(1'b1));
        chk("acc_mreq", 128'(mem_req), 128'(1'b0));
        chk("acc_done", 128'(done), 128'(1'b0));
        tick();
        if (!hold) req_valid = 1'b0;
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        if (a[1:0] != 2'b00) begin
            #1;
            chk("mis_done", 128'(done), 128'(1'b1));
            chk("mis_err", 128'(err), 128'(1'b1));
            chk("mis_stall", 128'(stall), 128'(1'b0));
            chk("mis_mreq", 128'(mem_req), 128'(1'b0));
            chk("mis_vrfwe", 128'(vrf_we), 128'(1'b0));
        end else begin
            for (int i = 0; i < 4; i++) begin
                ea = a + (32'(i) << 2);
                ed = wd[32*i +: 32];
                rd = model_read(ea);
                for (int w = 0; w <= int'(waits[2*i +: 2]); w++) begin
                    mem_ready = (w == int'(waits[2*i +: 2]));
                    mem_rdata = mem_ready ? rd : $urandom;
                    #1;
                    chk("beat_stall", 128'(stall), 128'(1'b1));
                    chk("beat_mreq", 128'(mem_req), 128'(1'b1));
                    chk("beat_we", 128'(mem_we), 128'(st));
                    chk("beat_addr", 128'(mem_addr), 128'(ea));
                    chk("beat_wstrb", 128'(mem_wstrb), st ? 128'(4'hF) : 128'(4'h0));
                    if (st) chk("beat_wdata", 128'(mem_wdata), 128'(ed));
                    chk("beat_done", 128'(done), 128'(1'b0));
                    tick();
                end
                if (st) mem_model[ea] = ed;
                else exp_vec[32*i +: 32] = rd;
            end
            mem_ready = 1'($urandom);
            #1;
            chk("fin_done", 128'(done), 128'(1'b1));
            chk("fin_err", 128'(err), 128'(1'b0));
            chk("fin_stall", 128'(stall), 128'(1'b0));
            chk("fin_mreq", 128'(mem_req), 128'(1'b0));
            chk("fin_vrfwe", 128'(vrf_we), 128'(!st));
            if (!st) begin
                chk("fin_waddr", 128'(vrf_waddr), 128'(v));
                chk("fin_wdata", vrf_wdata, exp_vec);
            end
        end
        tick();
        req_valid = 1'b0;
        #1;
        chk_idle("post");
    endtask

    initial begin
        logic        r_st;
        logic [31:0] r_a;
        int          sel;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_addr  = '0;
        req_vreg  = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        chk_idle("rst");
        chk("rst_mwe", 128'(mem_we), 128'(1'b0));
        chk("rst_maddr", 128'(mem_addr), 128'(0));
        chk("rst_mwdata", 128'(mem_wdata), 128'(0));
        chk("rst_wstrb", 128'(mem_wstrb), 128'(0));
        chk("rst_waddr", 128'(vrf_waddr), 128'(0));
        chk("rst_err", 128'(err), 128'(1'b0));
        reset = 1'b0;
        tick();

        // Directed: basic load with known memory words.
        mem_model[32'h100] = 32'h1111_1111;
        mem_model[32'h104] = 32'h2222_2222;
        mem_model[32'h108] = 32'h3333_3333;
        mem_model[32'h10C] = 32'h4444_4444;
        xfer(1'b0, 32'h100, 3'd3, '0, 8'h00, 1'b0);

        // Directed: store, then read back through a load.
        xfer(1'b1, 32'h200, 3'd1, 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, 8'h00, 1'b1);
        chk("st_word3", 128'(model_read(32'h20C)), 128'(32'hDEADBEEF));
        xfer(1'b0, 32'h200, 3'd5, '0, 8'h00, 1'b0);

        // Directed: two not-ready cycles on beat 1.
        xfer(1'b0, 32'h100, 3'd2, '0, 8'b00_00_10_00, 1'b1);

        // Directed: misaligned store and load.
        xfer(1'b1, 32'h202, 3'd0, {4{$urandom}}, 8'h00, 1'b0);
        xfer(1'b0, 32'h101, 3'd4, '0, 8'h00, 1'b1);

        // Directed: address wrap.
        xfer(1'b0, 32'hFFFF_FFF8, 3'd7, '0, 8'h00, 1'b0);

        // Directed: reset during beat 2 of a load.
        req_valid = 1'b1;
        req_store = 1'b0;
        req_addr  = 32'h100;
        req_vreg  = 3'd6;
        mem_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        mem_rdata = model_read(32'h100);
        tick();
        mem_rdata = model_read(32'h104);
        tick();
        #1;
        chk("abort_addr", 128'(mem_addr), 128'(32'h108));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk_idle("abort0");
        tick();
        chk_idle("abort1");
        tick();
        chk_idle("abort2");
        xfer(1'b0, 32'h100, 3'd6, '0, 8'h00, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            r_st = 1'($urandom);
            sel  = int'($urandom_range(0, 7));
            if (sel == 0)      r_a = {$urandom_range(0, 32'h3FFF_FFFF), 2'($urandom_range(1, 3))};
            else if (sel == 1) r_a = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else               r_a = 32'h300 + (32'($urandom_range(0, 15)) << 2);
            xfer(r_st, r_a, 3'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 8'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
